// File: rtl/issue_scoreboard_pkg.sv
// rtl/issue_scoreboard_pkg.sv - shared types and constants for the issue scoreboard
package issue_scoreboard_pkg;

  localparam int NUM_ARCH_REGS = 32;
  localparam int DEF_MAX_PEND  = 3;

  typedef logic [31:0] idrf_tdata_t;

  // Instruction as handed over by the register-file read stage.
  typedef struct packed {
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic        wb_en;
    idrf_tdata_t payload;
  } issue_tdata_t;

endpackage

// File: rtl/issue_scoreboard_if.sv
// rtl/issue_scoreboard_if.sv - valid/ready stream interface carrying issue payloads
interface axis_if #(
  parameter int TDATA_WIDTH = 8
);
  logic [TDATA_WIDTH-1:0] tdata;
  logic                   tvalid;
  logic                   tready;

  modport m (output tdata, output tvalid, input tready);
  modport s (input tdata, input tvalid, output tready);
endinterface

// File: rtl/issue_scoreboard_pend_counter.sv
// rtl/issue_scoreboard_pend_counter.sv - saturating pending-write counter for one register
module pend_counter #(
  parameter int MAX_PEND = 3,
  parameter int CNT_W    = $clog2(MAX_PEND + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             dec,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt,
  output logic             zero,
  output logic             full,
  output logic             err
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             dec_ok;

  assign zero   = (cnt_q == '0);
  assign full   = (cnt_q == CNT_W'(MAX_PEND));
  assign dec_ok = dec && !zero;
  // A retire with nothing outstanding is reported and otherwise ignored.
  assign err    = dec && zero;
  assign cnt    = cnt_q;

  // Next count: clear wins, simultaneous inc/dec cancel, both directions saturate.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && !dec_ok && !full) begin
      cnt_d = cnt_q + 1'b1;
    end else if (dec_ok && !inc) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  // Count register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/issue_scoreboard.sv
// rtl/issue_scoreboard.sv - register-dependency issue gate; ISSUE_SCOREBOARD_WB_BYPASS_EN enables writeback bypass
module issue_scoreboard
  import issue_scoreboard_pkg::*;
#(
  parameter int TDATA_WIDTH = $bits(issue_tdata_t),
  parameter int MAX_PEND    = DEF_MAX_PEND
) (
  input  logic        clk,
  input  logic        rst,
  axis_if.s           issue_sif,
  axis_if.m           issue_mif,
  input  logic        wb_vld,
  input  logic [4:0]  wb_rd,
  input  logic        invalidate,
  output logic [31:0] busy,
  output logic        wb_err
);

  localparam int CNT_W = $clog2(MAX_PEND + 1);
`ifdef ISSUE_SCOREBOARD_WB_BYPASS_EN
  localparam logic BYPASS = 1'b1;
`else
  localparam logic BYPASS = 1'b0;
`endif

  issue_tdata_t                   head;
  issue_tdata_t                   out_data_q, out_data_d;
  logic                           out_vld_q, out_vld_d;
  logic                           wb_err_q, wb_err_d;
  logic                           out_free, haz, accept, counted;
  logic [NUM_ARCH_REGS-1:1]       inc_vec, dec_vec, zero_vec, full_vec, err_vec;
  logic [NUM_ARCH_REGS-1:0]       src_busy, rd_full;
  logic [CNT_W-1:0]               cnt_arr [1:NUM_ARCH_REGS-1];

  assign head     = issue_tdata_t'(issue_sif.tdata);
  assign counted  = head.wb_en && (head.rd != 5'd0);
  assign out_free = !out_vld_q || issue_mif.tready;
  assign haz      = src_busy[head.rs1] || src_busy[head.rs2] || (counted && rd_full[head.rd]);

  assign issue_sif.tready = rst && out_free && !haz && !invalidate;
  assign accept           = issue_sif.tvalid && issue_sif.tready;

  // x0 is never tracked: it never blocks a source and never fills.
  assign src_busy[0] = 1'b0;
  assign rd_full[0]  = 1'b0;

  for (genvar r = 1; r < NUM_ARCH_REGS; r++) begin : g_reg
    assign inc_vec[r] = accept && counted && (head.rd == 5'(r));
    // Writebacks during a flush are dropped so they neither count down nor flag errors.
    assign dec_vec[r] = wb_vld && !invalidate && (wb_rd == 5'(r));

    pend_counter #(
      .MAX_PEND (MAX_PEND),
      .CNT_W    (CNT_W)
    ) u_cnt (
      .clk  (clk),
      .rst  (rst),
      .inc  (inc_vec[r]),
      .dec  (dec_vec[r]),
      .clr  (invalidate),
      .cnt  (cnt_arr[r]),
      .zero (zero_vec[r]),
      .full (full_vec[r]),
      .err  (err_vec[r])
    );

    // With bypass, the retiring last write frees the source in the same cycle.
    assign src_busy[r] = !zero_vec[r] && !(BYPASS && dec_vec[r] && (cnt_arr[r] == CNT_W'(1)));
    assign rd_full[r]  = full_vec[r] && !(BYPASS && dec_vec[r]);
  end

  assign busy          = {~zero_vec, 1'b0};
  assign wb_err        = wb_err_q;
  assign issue_mif.tvalid = out_vld_q;
  assign issue_mif.tdata  = out_data_q;

  // Output register: flush drops it, accept loads it, a consumed beat empties it.
  always_comb begin
    out_vld_d  = out_vld_q;
    out_data_d = out_data_q;
    if (invalidate) begin
      out_vld_d = 1'b0;
    end else if (accept) begin
      out_vld_d  = 1'b1;
      out_data_d = head;
    end else if (issue_mif.tready) begin
      out_vld_d = 1'b0;
    end
  end

  // Sticky error: any writeback to an idle register latches it until reset.
  always_comb begin
    wb_err_d = wb_err_q || (|err_vec);
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      out_vld_q  <= 1'b0;
      out_data_q <= '0;
      wb_err_q   <= 1'b0;
    end else begin
      out_vld_q  <= out_vld_d;
      out_data_q <= out_data_d;
      wb_err_q   <= wb_err_d;
    end
  end

endmodule

// File: tb/tb_issue_scoreboard.sv
// tb/tb_issue_scoreboard.sv - scoreboard bench for issue_scoreboard with directed and random traffic
module tb_issue_scoreboard;
  import issue_scoreboard_pkg::*;

  localparam int TW    = $bits(issue_tdata_t);
  localparam int MAX_P = 3;
`ifdef ISSUE_SCOREBOARD_WB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        wb_vld = 1'b0;
  logic        invalidate = 1'b0;
  logic [4:0]  wb_rd = 5'd0;
  logic [31:0] busy;
  logic        wb_err;

  axis_if #(.TDATA_WIDTH(TW)) sif_i ();
  axis_if #(.TDATA_WIDTH(TW)) mif_i ();

  issue_scoreboard #(.TDATA_WIDTH(TW), .MAX_PEND(MAX_P)) dut (
    .clk        (clk),
    .rst        (rst),
    .issue_sif  (sif_i),
    .issue_mif  (mif_i),
    .wb_vld     (wb_vld),
    .wb_rd      (wb_rd),
    .invalidate (invalidate),
    .busy       (busy),
    .wb_err     (wb_err)
  );

  always #5 clk = ~clk;

  int           checks = 0;
  int           errors = 0;
  int           cnt_m [32];
  bit           err_m = 1'b0;
  issue_tdata_t exp_q [$];
  bit           mon_en = 1'b0;
  logic         dut_acc;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic issue_tdata_t mk(input logic [4:0] rs1, input logic [4:0] rs2,
                                      input logic [4:0] rd, input logic we);
    issue_tdata_t d;
    d.rs1 = rs1; d.rs2 = rs2; d.rd = rd; d.wb_en = we; d.payload = $urandom;
    return d;
  endfunction

  function automatic bit src_blocks(input logic [4:0] r);
    return (r != 0) && (cnt_m[r] != 0) && !(BYP && wb_vld && wb_rd == r && cnt_m[r] == 1);
  endfunction

  // Reference model: decides readiness from pending counts, then applies the clock edge.
  task automatic model_step();
    issue_tdata_t d;
    bit haz, exp_rdy, acc;
    d = sif_i.tdata;
    haz = src_blocks(d.rs1) || src_blocks(d.rs2) ||
          (d.wb_en && d.rd != 0 && cnt_m[d.rd] == MAX_P && !(BYP && wb_vld && wb_rd == d.rd));
    exp_rdy = rst && (exp_q.size() == 0) && !haz && !invalidate;
    chk("sif_tready", sif_i.tready, exp_rdy);
    dut_acc = sif_i.tvalid && sif_i.tready;
    acc = sif_i.tvalid && exp_rdy;
    if (!rst) begin
      cnt_m = '{default: 0}; err_m = 1'b0; exp_q.delete();
    end else if (invalidate) begin
      cnt_m = '{default: 0}; exp_q.delete();
    end else begin
      if (wb_vld && wb_rd != 0) begin
        if (cnt_m[wb_rd] == 0) err_m = 1'b1;
        else cnt_m[wb_rd]--;
      end
      if (acc) begin
        exp_q.push_back(d);
        if (d.wb_en && d.rd != 0) cnt_m[d.rd]++;
      end
    end
  endtask

  task automatic step(input bit v, input issue_tdata_t d, input bit mr, input bit wv,
                      input logic [4:0] wr, input bit inv, input bit r);
    @(negedge clk);
    rst = r; sif_i.tvalid = v; sif_i.tdata = d; mif_i.tready = mr;
    wb_vld = wv; wb_rd = wr; invalidate = inv;
    #3;
    model_step();
  endtask

  // Monitor: compares state outputs every cycle and pops the expected beat on a handshake.
  always @(negedge clk) begin : monitor
    logic [31:0] eb;
    #1;
    if (mon_en) begin
      eb = '0;
      for (int r = 1; r < 32; r++) eb[r] = (cnt_m[r] != 0);
      chk("busy", busy, eb);
      chk("wb_err", wb_err, err_m);
      chk("m_tvalid", mif_i.tvalid, exp_q.size() != 0);
      if (mif_i.tvalid && exp_q.size() != 0) begin
        chk("m_tdata", mif_i.tdata, exp_q[0]);
        if (mif_i.tready && rst) void'(exp_q.pop_front());
      end
    end
  end

  initial begin
    issue_tdata_t i2;
    sif_i.tvalid = 1'b0; sif_i.tdata = '0; mif_i.tready = 1'b0;
    repeat (3) step(0, '0, 0, 0, 0, 0, 0);
    chk("rst_tvalid", mif_i.tvalid, 0);
    chk("rst_tdata", mif_i.tdata, 0);
    chk("rst_busy", busy, 0);
    chk("rst_wb_err", wb_err, 0);
    mon_en = 1'b1;

    // back-to-back independent instructions
    for (int k = 1; k <= 3; k++) begin
      step(1, mk(0, 0, 5'(k), 1), 1, 0, 0, 0, 1);
      chk("b2b_accept", dut_acc, 1);
    end
    step(0, '0, 1, 0, 0, 0, 1);
    chk("b2b_busy", busy, 32'h0000000E);
    for (int k = 1; k <= 3; k++) step(0, '0, 1, 1, 5'(k), 0, 1);

    // RAW: consumer waits for the writeback of r5
    step(1, mk(0, 0, 5, 1), 1, 0, 0, 0, 1);
    chk("raw_producer", dut_acc, 1);
    i2 = mk(5, 0, 0, 0);
    for (int k = 0; k < 3; k++) begin
      step(1, i2, 1, 0, 0, 0, 1);
      chk("raw_stall", dut_acc, 0);
    end
    step(1, i2, 1, 1, 5, 0, 1);
    chk("raw_wb_cycle", dut_acc, BYP);
    if (!dut_acc) begin
      step(1, i2, 1, 0, 0, 0, 1);
      chk("raw_after_wb", dut_acc, 1);
    end

    // WAW saturation on r7
    for (int k = 0; k < 3; k++) begin
      step(1, mk(0, 0, 7, 1), 1, 0, 0, 0, 1);
      chk("waw_accept", dut_acc, 1);
    end
    i2 = mk(0, 0, 7, 1);
    for (int k = 0; k < 2; k++) begin
      step(1, i2, 1, 0, 0, 0, 1);
      chk("waw_stall", dut_acc, 0);
    end
    chk("waw_busy7", busy[7], 1);
    step(1, i2, 1, 1, 7, 0, 1);
    chk("waw_wb_cycle", dut_acc, BYP);
    if (!dut_acc) begin
      step(1, i2, 1, 0, 0, 0, 1);
      chk("waw_after_wb", dut_acc, 1);
    end
    for (int k = 0; k < 3; k++) step(0, '0, 1, 1, 7, 0, 1);
    step(0, '0, 1, 0, 0, 0, 1);
    chk("waw_drained", busy, 0);

    // output backpressure
    step(1, mk(0, 0, 0, 0), 0, 0, 0, 0, 1);
    chk("bp_load", dut_acc, 1);
    for (int k = 0; k < 5; k++) begin
      step(1, mk(0, 0, 0, 0), 0, 0, 0, 0, 1);
      chk("bp_stall", dut_acc, 0);
    end
    step(0, '0, 1, 0, 0, 0, 1);

    // invalidate with r3 pending twice and a valid output
    step(1, mk(0, 0, 3, 1), 1, 0, 0, 0, 1);
    step(1, mk(0, 0, 3, 1), 1, 0, 0, 0, 1);
    chk("inv_setup", dut_acc, 1);
    step(0, '0, 0, 1, 3, 1, 1);
    step(0, '0, 0, 0, 0, 0, 1);
    chk("inv_busy", busy, 0);
    chk("inv_tvalid", mif_i.tvalid, 0);
    chk("inv_wb_err", wb_err, 0);
    step(0, '0, 1, 1, 3, 0, 1);
    step(0, '0, 1, 0, 0, 0, 1);
    chk("inv_late_wb_err", wb_err, 1);

    // reset in the middle of a stall
    step(1, mk(0, 0, 9, 1), 1, 0, 0, 0, 1);
    i2 = mk(9, 0, 0, 0);
    step(1, i2, 1, 0, 0, 0, 1);
    chk("rst2_stall", dut_acc, 0);
    step(1, i2, 1, 0, 0, 0, 0);
    step(1, i2, 1, 0, 0, 0, 1);
    chk("rst2_busy", busy, 0);
    chk("rst2_tvalid", mif_i.tvalid, 0);
    chk("rst2_tdata", mif_i.tdata, 0);
    chk("rst2_wb_err", wb_err, 0);
    chk("rst2_issue", dut_acc, 1);

    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      logic [4:0] wr;
      int pick;
      wr = 5'($urandom_range(0, 7));
      if ($urandom_range(0, 9) != 0) begin
        for (int t = 0; t < 8; t++) begin
          pick = int'($urandom_range(1, 7));
          if (cnt_m[pick] != 0) begin
            wr = 5'(pick);
            break;
          end
        end
      end
      step($urandom_range(0, 3) != 0,
           mk(5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
              1'($urandom_range(0, 1))),
           $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0, wr,
           $urandom_range(0, 49) == 0, $urandom_range(0, 99) != 0);
    end
    repeat (4) step(0, '0, 1, 0, 0, 0, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/issue_scoreboard.md
Name: issue_scoreboard

Overview:
- Register-dependency scheduler between the register-file read stage and the execution units (ALU/BRU/LSU).
- Tracks outstanding destination writes per architectural register.
- Holds an instruction while any source it reads, or its destination, has an unfinished write.
- Issues through a one-entry output register; counters are cleared on pipeline invalidate.

Parameters:
- TDATA_WIDTH, $bits(issue_tdata_t): width of the instruction payload carried through.
- MAX_PEND, 3: maximum outstanding writes per register; counter width CNT_W = $clog2(MAX_PEND+1).

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-low (asserted when 0)
- issue_sif  axis_if.s  TDATA_WIDTH  instruction from register-file stage; tdata is issue_tdata_t (rs1, rs2, rd, wb_en, payload)
- issue_mif  axis_if.m  TDATA_WIDTH  instruction to execution units
- wb_vld  in  1  writeback retires one write this cycle
- wb_rd  in  5  register retired by writeback
- invalidate  in  1  pipeline flush
- busy  out  32  bit r = (cnt[r] != 0); bit 0 always 0
- wb_err  out  1  sticky: a writeback arrived for a register with cnt 0

Behaviour:
- Reset (rst==0 at a clk edge):
  - all cnt[1..31] = 0.
  - issue_mif.tvalid = 0, issue_mif.tdata = 0.
  - wb_err = 0.
  - issue_sif.tready = 0 during reset.
- Register x0:
  - Never tracked; rs == 0 never blocks.
  - rd == 0 or wb_en == 0 is never counted.
  - A writeback with wb_rd == 0 is ignored.
- Hazard for the head instruction, haz:
  - (rs1 != 0 && cnt[rs1] != 0), or
  - (rs2 != 0 && cnt[rs2] != 0), or
  - (wb_en && rd != 0 && cnt[rd] == MAX_PEND).
- Output register:
  - out_free = !issue_mif.tvalid || issue_mif.tready.
  - issue_sif.tready = out_free && !haz && !invalidate; combinational from tdata and counters.
  - On accept (issue_sif.tvalid && tready): the output register loads tdata and tvalid = 1 next cycle.
  - Latency is exactly 1 cycle; throughput is 1 instruction per cycle when there is no hazard.
  - If issue_mif.tready && !accept, tvalid drops to 0.
  - While tvalid && !tready, tdata is held stable.
- Counters:
  - Accept with a counted rd increments cnt[rd].
  - wb_vld with cnt[wb_rd] != 0 decrements cnt[wb_rd].
  - Same register incremented and decremented in the same cycle: net unchanged.
  - wb_vld with cnt[wb_rd] == 0: counter stays 0 and wb_err is set.
  - Counters never wrap; the MAX_PEND stall guarantees this.
- Hazard source: haz uses the registered counters only, so the writeback retiring the last pending write unblocks the instruction on the following cycle (one bubble).
- Invalidate:
  - Next cycle: issue_mif.tvalid = 0 and all counters = 0.
  - No accept in the invalidate cycle.
  - wb_vld in the invalidate cycle is ignored and does not set wb_err.
  - wb_err is not cleared.
- Reset mid-operation: identical to power-on reset; any in-flight handshake is discarded.

Optional Feature:
- Macro: ISSUE_SCOREBOARD_WB_BYPASS_EN.
- Defined: a source whose cnt == 1 and which matches wb_rd with wb_vld this cycle is treated as not busy, removing the bubble. The same applies to a rd at MAX_PEND whose count is being decremented this cycle.
- Undefined: registered-counter check only, as described under Behaviour.

Decomposition:
- offnariscv_pkg gets:
  - issue_tdata_t (rs1[4:0], rs2[4:0], rd[4:0], wb_en, payload as idrf_tdata_t).
  - localparam NUM_ARCH_REGS = 32.
- Sub-module pend_counter (one per register, generate loop over 1..31):
  - Inputs: inc, dec, clr.
  - Outputs: cnt, zero, full, err.
  - Saturating up/down counter with synchronous active-low reset.
- The output register is written inline; axis_slice is not reused because the hazard gating must sit on the handshake.

Test Plan:
- Back-to-back independent instructions (rd = 1, 2, 3; rs = 0), issue_mif.tready = 1:
  - accepted on 3 consecutive cycles;
  - tvalid high in cycles 1-3;
  - busy = 0x0000000E after cycle 3.
- RAW: issue rd = 5, then rs1 = 5; wb_vld/wb_rd = 5 four cycles later:
  - without the macro, the second instruction is accepted 1 cycle after the wb;
  - with the macro, in the same cycle as the wb.
- WAW saturation, MAX_PEND = 3: four instructions all with rd = 7 and no wb:
  - the fourth stalls with cnt[7] = 3;
  - one wb to 7 lets it issue; cnt[7] is back at 3.
- Output backpressure: issue_mif.tready = 0 for 5 cycles with a valid output:
  - issue_sif.tready = 0;
  - issue_mif.tdata is held constant;
  - no counter changes.
- Invalidate with cnt[3] = 2, the output register valid, and wb_vld to 3 in the same cycle:
  - next cycle busy = 0, tvalid = 0, wb_err = 0.
  - A subsequent wb to 3 then sets wb_err = 1.
- Reset asserted (rst = 0) mid-stall:
  - all outputs return to their reset values on the next edge;
  - after deassertion, the blocked instruction issues immediately.
